// File: rtl/mem_alu_pkg.sv
// mem_alu_pkg: shared definitions for the memory-to-memory ALU.
//   - opcode encodings OP_ADD..OP_ILL
//   - FSM state encoding (2 bits)
//   - bit positions of C, Z and N inside the 3-bit flags vector
//   - instruction field extraction helpers, parametrised by the address width
package mem_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_ADC = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // flags = {C, Z, N}
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;

  // Field slot numbers within the instruction, counted from the LSB in units of AW.
  localparam int FLD_D = 0;
  localparam int FLD_B = 1;
  localparam int FLD_A = 2;

  // Widest address width the helpers support; callers zero-extend the
  // instruction into MAX_IW bits and cast the returned field down to AW.
  localparam int MAX_AW = 16;
  localparam int MAX_IW = 4 + 3*MAX_AW;

  function automatic logic [3:0] get_op(input logic [MAX_IW-1:0] ins, input int aw);
    return 4'(ins >> (3*aw));
  endfunction

  function automatic logic [MAX_AW-1:0] get_field(input logic [MAX_IW-1:0] ins,
                                                  input int aw, input int slot);
    logic [MAX_IW-1:0] shifted;
    logic [MAX_IW-1:0] mask;
    shifted = ins >> (slot*aw);
    mask    = ~({MAX_IW{1'b1}} << aw);
    return MAX_AW'(shifted & mask);
  endfunction

endpackage

// File: rtl/mem_alu_unit_alu_core.sv
// alu_core: purely combinational ALU for mem_alu_unit.
//   op        : opcode
//   a, b      : source operands
//   imm       : immediate for LDI, already sized to DW
//   cin       : current carry flag (used by ADC)
//   result    : ALU result (0 for NOP / illegal)
//   cout      : new C value; carry for add-type, borrow for sub-type, 0 where C is cleared
//   writes_en : destination word is written
//   flag_mask : per-flag update enable, indexed by FLAG_C/FLAG_Z/FLAG_N
module alu_core
  import mem_alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic          cout,
  output logic          writes_en,
  output logic [2:0]    flag_mask
);

  // One extra bit so the MSB is carry-out on add and borrow on subtract.
  logic [DW:0] ext;

  always_comb begin
    result    = '0;
    cout      = 1'b0;
    writes_en = 1'b1;
    flag_mask = 3'b111;
    ext       = '0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[DW-1:0];
        cout   = ext[DW];
      end
      OP_SUB: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[DW-1:0];
        cout   = ext[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        cout   = a[DW-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        cout   = a[0];
      end
      OP_MOV: result = a;
      OP_ADC: begin
        ext    = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        result = ext[DW-1:0];
        cout   = ext[DW];
      end
      OP_INC: begin
        ext    = {1'b0, a} + {{DW{1'b0}}, 1'b1};
        result = ext[DW-1:0];
        cout   = ext[DW];
      end
      OP_DEC: begin
        ext    = {1'b0, a} - {{DW{1'b0}}, 1'b1};
        result = ext[DW-1:0];
        cout   = ext[DW];
      end
      OP_CMP: begin
        ext       = {1'b0, a} - {1'b0, b};
        result    = ext[DW-1:0];
        cout      = ext[DW];
        writes_en = 1'b0;
      end
      OP_LDI: result = imm;
      default: begin
        // NOP and illegal: no write, flags untouched
        writes_en = 1'b0;
        flag_mask = 3'b000;
      end
    endcase
  end

endmodule

// File: rtl/mem_alu_unit.sv
// mem_alu_unit: memory-to-memory ALU with a DEPTH x DW scratch memory.
// One instruction {op, a, b, d} per handshake; reads mem[a] and mem[b],
// computes, writes mem[d]. Four cycles per instruction.
//   clk, rst          : clock, synchronous active-high reset
//   instr_valid/instr : instruction handshake input (instr sampled only in IDLE)
//   instr_ready       : high in IDLE
//   op_a, op_b        : registered source operands
//   result            : registered ALU result
//   flags             : {C, Z, N}
//   done, illegal     : one-cycle retire pulse; illegal accompanies done for op 0xF
//   memory            : flattened memory image, word i at [i*DW +: DW]
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | ready; latch instr when instr_valid
// ST_READ  | capture op_a = mem[a], op_b = mem[b]
// ST_EXEC  | register result and next flags, raise done/illegal
// ST_WRITE | write mem[d] if the op writes, commit flags, drop done
module mem_alu_unit
  import mem_alu_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int AW    = 4,
  localparam int IW    = 4 + 3*AW,
  localparam int DEPTH = 2**AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [IW-1:0]       instr,
  output logic                instr_ready,
  output logic [DW-1:0]       op_a,
  output logic [DW-1:0]       op_b,
  output logic [DW-1:0]       result,
  output logic [2:0]          flags,
  output logic                done,
  output logic                illegal,
  output logic [DW*DEPTH-1:0] memory
);

  state_t        state;
  logic [IW-1:0] instr_q;
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    flags_nx;
  logic          wr_pend;

  logic [3:0]    op_f;
  logic [AW-1:0] a_f;
  logic [AW-1:0] b_f;
  logic [AW-1:0] d_f;
  logic [DW-1:0] imm;

  logic [DW-1:0] alu_res;
  logic          alu_cout;
  logic          alu_wr;
  logic [2:0]    alu_mask;
  logic [2:0]    alu_flags;

  assign op_f = get_op(MAX_IW'(instr_q), AW);
  assign a_f  = AW'(get_field(MAX_IW'(instr_q), AW, FLD_A));
  assign b_f  = AW'(get_field(MAX_IW'(instr_q), AW, FLD_B));
  assign d_f  = AW'(get_field(MAX_IW'(instr_q), AW, FLD_D));

  // LDI immediate is the raw {a,b} field pair, zero-extended or truncated to DW.
  assign imm = DW'({a_f, b_f});

  assign instr_ready = (state == ST_IDLE);

  alu_core #(.DW(DW)) u_alu (
    .op        (op_f),
    .a         (op_a),
    .b         (op_b),
    .imm       (imm),
    .cin       (flags[FLAG_C]),
    .result    (alu_res),
    .cout      (alu_cout),
    .writes_en (alu_wr),
    .flag_mask (alu_mask)
  );

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_cout;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[DW-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem_out
    assign memory[i*DW +: DW] = mem[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      instr_q  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      flags    <= '0;
      flags_nx <= '0;
      wr_pend  <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          op_a  <= mem[a_f];
          op_b  <= mem[b_f];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result   <= alu_res;
          // Masked-off flags keep their current value.
          flags_nx <= (alu_mask & alu_flags) | (~alu_mask & flags);
          wr_pend  <= alu_wr;
          done     <= 1'b1;
          illegal  <= (op_f == OP_ILL);
          state    <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wr_pend) mem[d_f] <= result;
          flags   <= flags_nx;
          done    <= 1'b0;
          illegal <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
